// File: rtl/fire_sched_pkg.sv
// Shared types and constants for the transition fire scheduler.
// State encoding, LFSR reset value/taps, mode codes.
package fire_sched_pkg;

  typedef enum logic [1:0] {
    ST_HALT,
    ST_PICK,
    ST_FIRE,
    ST_DEAD
  } state_e;

  localparam logic [15:0] LFSR_RST  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_RAND = 1'b1;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fire_rr_pick.sv
// Rotating-priority picker: first set bit of excited at or
// after start, wrapping from N-1 back to 0.
module fire_rr_pick #(
  parameter int N      = 4,
  parameter int FIRE_W = $clog2(N + 1)
) (
  input  logic [N-1:0]      excited_i,
  input  logic [FIRE_W-1:0] start_i,
  output logic [FIRE_W-1:0] pick_o,
  output logic              any_o
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic found;

  // scan N positions from start, keep the first hit
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    any_o  = |excited_i;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!found && excited_i[IDXW'(j)]) begin
        pick_o = FIRE_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fire_scheduler.sv
// Picks and issues one excited transition per PICK/FIRE pair.
// Optional FIRE_SCHED_FAIRNESS_EN adds per-transition age override.
module fire_scheduler
  import fire_sched_pkg::*;
#(
  parameter int N         = 4,
  parameter int FIRE_W    = $clog2(N + 1),
  parameter int CNT_W     = 32,
  parameter int DL_CYCLES = 3,
  parameter int MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic [N-1:0]      excited,
  output logic [FIRE_W-1:0] fire,
  output logic              fire_valid,
  output logic              deadlock,
  output logic [CNT_W-1:0]  fire_count
);

  localparam int IW = $clog2(DL_CYCLES + 1);
  localparam logic [FIRE_W-1:0] IDLE = FIRE_W'(N);
  localparam logic [IW-1:0] DL_LIM = IW'(DL_CYCLES);

  state_e            state_q, state_d;
  logic [FIRE_W-1:0] fire_q, fire_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [FIRE_W-1:0] rr_q, rr_d;
  logic              pend_q, pend_d;
  logic [IW-1:0]     idle_q, idle_d;

  logic [FIRE_W-1:0] rnd_v, rnd_s, start;
  logic [FIRE_W-1:0] arb_c, choice;
  logic              any;
  logic              fire_now;
  logic [IW-1:0]     idle_inc;

  assign rnd_v = lfsr_q[FIRE_W-1:0];
  assign rnd_s = (rnd_v >= IDLE) ? rnd_v - IDLE : rnd_v;
  assign start = (mode == MODE_RAND) ? rnd_s : rr_q;

  fire_rr_pick #(
    .N      (N),
    .FIRE_W (FIRE_W)
  ) u_pick (
    .excited_i (excited),
    .start_i   (start),
    .pick_o    (arb_c),
    .any_o     (any)
  );

  assign fire_now = (state_q == ST_PICK) && any;
  assign idle_inc = idle_q + 1'b1;

`ifdef FIRE_SCHED_FAIRNESS_EN
  localparam int AW   = $clog2(MAX_WAIT + 1);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] AMAX = AW'(MAX_WAIT);

  logic [N-1:0][AW-1:0] age_q, age_d;
  logic                 ovr;
  logic [FIRE_W-1:0]    ovr_c;

  // a starved transition beats the arbiter, lowest index first
  always_comb begin
    ovr   = 1'b0;
    ovr_c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (excited[IDXW'(i)] && age_q[IDXW'(i)] == AMAX) begin
        ovr   = 1'b1;
        ovr_c = FIRE_W'(i);
      end
    end
  end

  assign choice = ovr ? ovr_c : arb_c;

  // age grows when passed over in a firing pick, saturating
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      if (!excited[IDXW'(i)]) begin
        age_d[IDXW'(i)] = '0;
      end else if (fire_now) begin
        if (choice == FIRE_W'(i))
          age_d[IDXW'(i)] = '0;
        else if (age_q[IDXW'(i)] != AMAX)
          age_d[IDXW'(i)] = age_q[IDXW'(i)] + 1'b1;
      end
    end
  end

  // age register bank
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) age_q <= '0;
    else        age_q <= age_d;
  end
`else
  logic unused_mw;
  assign unused_mw = (MAX_WAIT != 0);
  assign choice    = arb_c;
`endif

  // sequencing: halt/pick/fire/dead and all datapath updates
  always_comb begin
    state_d = state_q;
    fire_d  = fire_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    idle_d  = idle_q;
    unique case (state_q)
      ST_HALT: begin
        if (run || pend_q) state_d = ST_PICK;
      end
      ST_PICK: begin
        if (any) begin
          fire_d  = choice;
          idle_d  = '0;
          pend_d  = 1'b0;
          lfsr_d  = lfsr_next(lfsr_q);
          rr_d    = (choice == FIRE_W'(N - 1)) ? '0
                                               : choice + 1'b1;
          state_d = ST_FIRE;
        end else begin
          idle_d = idle_inc;
          if (idle_inc == DL_LIM)   state_d = ST_DEAD;
          else if (!run && !pend_q) state_d = ST_HALT;
        end
      end
      ST_FIRE: begin
        cnt_d   = cnt_q + 1'b1;
        fire_d  = IDLE;
        state_d = run ? ST_PICK : ST_HALT;
      end
      ST_DEAD: begin
        if (!run) begin
          state_d = ST_HALT;
          idle_d  = '0;
        end else if (any) begin
          state_d = ST_PICK;
          idle_d  = '0;
        end
      end
      default: state_d = ST_HALT;
    endcase
    if (seed_load) lfsr_d = (seed == '0) ? LFSR_RST : seed;
    if (step && !run) pend_d = 1'b1;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HALT;
      fire_q  <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_RST;
      rr_q    <= '0;
      pend_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      idle_q  <= idle_d;
    end
  end

  assign fire       = fire_q;
  assign fire_valid = (fire_q != IDLE);
  assign deadlock   = (state_q == ST_DEAD);
  assign fire_count = cnt_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler with a fire scoreboard.
// Fairness section runs when FIRE_SCHED_FAIRNESS_EN is defined.
module tb_fire_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic        mode;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  excited;
  logic [2:0]  fire;
  logic        fire_valid;
  logic        deadlock;
  logic [31:0] fire_count;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  fire_scheduler #(
    .N         (4),
    .FIRE_W    (3),
    .CNT_W     (32),
    .DL_CYCLES (3),
    .MAX_WAIT  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .mode       (mode),
    .seed_load  (seed_load),
    .seed       (seed),
    .excited    (excited),
    .fire       (fire),
    .fire_valid (fire_valid),
    .deadlock   (deadlock),
    .fire_count (fire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (fire_valid === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_pop: observed fire=%0d, expected no fire", fire);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_fire", fire, e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
  endtask

  function automatic logic [15:0] m_lfsr(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  initial begin
    int seq2[9];
    int nv;
    int gap;
    logic [15:0] ml;
    logic [2:0]  s;

    reset = 1'b0; run = 1'b0; step = 1'b0; mode = 1'b0;
    seed_load = 1'b0; seed = '0; excited = '0;
    tick();
    tick();
    chk("rst_fire", fire, 3'd4);
    chk("rst_valid", fire_valid, 1'b0);
    chk("rst_dead", deadlock, 1'b0);
    chk("rst_count", fire_count, 32'd0);
    chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
    reset = 1'b1;

    // deadlock after three empty picks, cleared by excitation
    run = 1'b1;
    tick(); tick(); tick();
    chk("dl_early", deadlock, 1'b0);
    tick();
    chk("dl_set", deadlock, 1'b1);
    chk("dl_fire", fire, 3'd4);
    excited = 4'b0010;
    sb.push_back(1);
    tick();
    chk("dl_clear", deadlock, 1'b0);
    tick();
    chk("dl_fire1", fire, 3'd1);
    run = 1'b0;
    tick();
    chk("dl_count", fire_count, 32'd1);
    chk("dl_sb", sb.size(), 0);

    // round robin over all-excited
    do_reset();
    excited = 4'b1111;
    run = 1'b1;
    seq2 = '{0, 4, 1, 4, 2, 4, 3, 4, 0};
    sb.push_back(0); sb.push_back(1); sb.push_back(2);
    sb.push_back(3); sb.push_back(0);
    tick();
    chk("rr_first", fire, 3'd4);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_seq", fire, seq2[i]);
      if (i == 7) chk("rr_count4", fire_count, 32'd4);
    end
    run = 1'b0;
    tick();
    chk("rr_count5", fire_count, 32'd5);
    chk("rr_sb", sb.size(), 0);

    // random mode, single excited transition
    do_reset();
    mode = 1'b1;
    seed = 16'h1234;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("seed_ld", dut.lfsr_q, 16'h1234);
    excited = 4'b0100;
    run = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(2);
    for (int i = 0; i < 10; i++) tick();
    chk("rnd_sb", sb.size(), 0);
    run = 1'b0;
    tick(); tick();
    seed = 16'h0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("seed_zero", dut.lfsr_q, 16'hACE1);

    // random choices predicted from an LFSR model
    excited = 4'b1111;
    ml = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      s = ml[2:0];
      if (s >= 3'd4) s = s - 3'd4;
      sb.push_back(int'(s));
      ml = m_lfsr(ml);
    end
    run = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("lfsr_sb", sb.size(), 0);
    run = 1'b0;
    tick(); tick();

    // single step
    do_reset();
    mode = 1'b0;
    excited = 4'b1111;
    tick(); tick(); tick();
    chk("halt_idle", fire_valid, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    sb.push_back(0);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fire_valid === 1'b1) nv++;
    end
    chk("step_once", nv, 1);
    chk("step_count", fire_count, 32'd1);
    chk("step_halt", dut.state_q, 2'd0);

    // asynchronous reset mid-fire
    do_reset();
    run = 1'b1;
    sb.push_back(0); sb.push_back(1);
    for (int i = 0; i < 4; i++) tick();
    chk("ar_pre", fire, 3'd1);
    reset = 1'b0;
    #1;
    chk("ar_fire", fire, 3'd4);
    chk("ar_count", fire_count, 32'd0);
    tick();
    reset = 1'b1;
    sb.delete();
    sb.push_back(0);
    tick(); tick();
    chk("ar_restart", fire, 3'd0);
    chk("ar_sb", sb.size(), 0);
    run = 1'b0;
    tick();

`ifdef FIRE_SCHED_FAIRNESS_EN
    // transition 1 never waits more than two fires
    do_reset();
    mode = 1'b1;
    seed = 16'h5A5A;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    excited = 4'b0011;
    run = 1'b1;
    gap = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (fire_valid === 1'b1) begin
        if (fire === 3'd1) gap = 0;
        else gap++;
        chk("fair_gap", gap <= 2, 1'b1);
      end
    end
    run = 1'b0;
`else
    gap = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
